sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 92 +++++++++
 tb/tb_sum_accumulator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES 2-bit sums into an ACC_W-bit total with a sticky carry-out flag,
// using a start / valid-ready input / valid-ready output protocol.
module sum_accumulator #(
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [1:0]       in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             busy
);

  if (ACC_W < 3 || ACC_W > 32) begin : g_bad_acc_w
    $error("sum_accumulator: ACC_W must be in 3..32");
  end
  if (N_SAMPLES < 1 || N_SAMPLES > 255) begin : g_bad_n_samples
    $error("sum_accumulator: N_SAMPLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic             ovf;
  logic [ACC_W:0]   sum;

  // One extra bit so the carry out of each addition is visible.
  assign sum = {1'b0, acc} + {{(ACC_W - 1){1'b0}}, in_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= sum[ACC_W-1:0];
            ovf   <= ovf | sum[ACC_W];
            count <= count + 8'd1;
            if (count == LAST) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The result registers double as outputs, so they hold after the handshake.
  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign out_total = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: an 8-bit and a 3-bit instance share stimulus and are
// checked every cycle against an arithmetic model of the run, plus literal expectations.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [1:0] in_sum;
  logic       out_ready;

  logic       in_ready8, out_valid8, out_ovf8, busy8;
  logic [7:0] out_total8;
  logic       in_ready3, out_valid3, out_ovf3, busy3;
  logic [2:0] out_total3;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  sum_accumulator #(.ACC_W(8), .N_SAMPLES(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready),
    .out_total(out_total8), .out_ovf(out_ovf8), .busy(busy8)
  );

  sum_accumulator #(.ACC_W(3), .N_SAMPLES(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_total(out_total3), .out_ovf(out_ovf3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting for start, 1 = collecting samples, 2 = result offered.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_sum   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_sum   = 0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1;
          m_cnt   = 0;
          m_sum   = 0;
        end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          m_sum = m_sum + int'(in_sum);
          m_cnt = m_cnt + 1;
          if (m_cnt == 4) m_phase = 2;
        end
      end else if (out_ready) begin
        m_phase = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A wrapped total with non-negative addends carried iff the exact sum reached 2^W.
  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready8",  32'(in_ready8),  32'(m_phase == 1));
      check("busy8",      32'(busy8),      32'(m_phase != 0));
      check("out_valid8", 32'(out_valid8), 32'(m_phase == 2));
      check("out_total8", 32'(out_total8), 32'(m_sum % 256));
      check("out_ovf8",   32'(out_ovf8),   32'(m_sum >= 256));
      check("in_ready3",  32'(in_ready3),  32'(m_phase == 1));
      check("busy3",      32'(busy3),      32'(m_phase != 0));
      check("out_valid3", 32'(out_valid3), 32'(m_phase == 2));
      check("out_total3", 32'(out_total3), 32'(m_sum % 8));
      check("out_ovf3",   32'(out_ovf3),   32'(m_sum >= 8));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit v, input logic [1:0] s);
    in_valid = v;
    in_sum   = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !out_valid8; i++) tick();
    check("done_timeout", 32'(out_valid8), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_sum = 2'd0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    // Asynchronous reset, before any clock edge.
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_busy",      32'(busy8),      32'd0);
    check("rst_in_ready",  32'(in_ready8),  32'd0);
    check("rst_total",     32'(out_total8), 32'd0);
    check("rst_ovf",       32'(out_ovf8),   32'd0);
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;

    // Valid samples while idle are ignored.
    in_valid = 1'b1; in_sum = 2'd3;
    repeat (3) tick();
    in_valid = 1'b0;
    check("idle_total", 32'(out_total8), 32'd0);

    // Back-to-back samples 0,1,1,2.
    do_start();
    push(1, 2'd0); push(1, 2'd1); push(1, 2'd1); push(1, 2'd2);
    check("run1_valid", 32'(out_valid8), 32'd1);
    check("run1_total", 32'(out_total8), 32'd4);
    check("run1_ovf",   32'(out_ovf8),   32'd0);
    check("run1_busy",  32'(busy8),      32'd1);
    handshake();
    check("run1_idle", 32'(busy8), 32'd0);

    // Gapped samples, then back-pressure for five cycles.
    do_start();
    push(1, 2'd0); push(0, 2'd3); push(0, 2'd3); push(1, 2'd1);
    push(0, 2'd3); push(1, 2'd1); push(1, 2'd2);
    repeat (5) begin
      tick();
      check("hold_valid", 32'(out_valid8), 32'd1);
      check("hold_total", 32'(out_total8), 32'd4);
    end
    handshake();
    check("hold_release", 32'(out_valid8), 32'd0);
    check("kept_total",   32'(out_total8), 32'd4);

    // Wrap-around: the 3-bit instance overflows, the 8-bit one does not.
    do_start();
    repeat (4) push(1, 2'd2);
    wait_done();
    check("wrap_total3", 32'(out_total3), 32'd0);
    check("wrap_ovf3",   32'(out_ovf3),   32'd1);
    check("wrap_total8", 32'(out_total8), 32'd8);
    handshake();
    do_start();
    check("ovf_cleared3", 32'(out_ovf3), 32'd0);
    repeat (4) push(1, 2'd1);
    wait_done();
    check("next_total3", 32'(out_total3), 32'd4);
    check("next_ovf3",   32'(out_ovf3),   32'd0);
    handshake();

    // Reset mid-run after two samples.
    do_start();
    push(1, 2'd3); push(1, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(busy8),      32'd0);
    check("midrst_total", 32'(out_total8), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    do_start();
    repeat (4) push(1, 2'd3);
    wait_done();
    check("rst_run_total8", 32'(out_total8), 32'd12);
    check("rst_run_ovf8",   32'(out_ovf8),   32'd0);
    check("rst_run_total3", 32'(out_total3), 32'd4);
    check("rst_run_ovf3",   32'(out_ovf3),   32'd1);
    handshake();

    // start is ignored outside idle, including the handshake cycle.
    do_start();
    start = 1'b1;
    push(1, 2'd1);
    push(1, 2'd1);
    start = 1'b0;
    push(1, 2'd1); push(1, 2'd0);
    wait_done();
    start = 1'b1;
    handshake();
    start = 1'b0;
    check("hs_start_idle", 32'(busy8),      32'd0);
    tick();
    check("hs_start_held", 32'(out_total8), 32'd3);
    do_start();
    check("restart_clear", 32'(out_total8), 32'd0);
    repeat (4) push(1, 2'd0);
    wait_done();
    handshake();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
